bin_window_feeder: RTL
======================

Name: bin_window_feeder

Overview:
Front-end sequencer for the 7x7 XNOR-popcount multiplier. It shift-loads a 7x7 binary weight kernel and a sliding 7-row binarized image window from 7-bit row streams, then presents them as 49-bit `img`/`w` vectors. It drives the multiplier's clear and accumulate strobes for 7 cycles, captures the 7-bit popcount sum and returns it with a binarized activation over a valid/ready handshake.

Parameters:
THRESH, 25, activation threshold; res_bit = 1 when popcount >= THRESH (range 0..49).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
w_in  in  7  weight row
w_load  in  1  shift w_in into weight register (honoured in FILL only)
row_in  in  7  binarized image row
row_valid  in  1  row_in valid
row_ready  out  1  feeder accepts a row this cycle
flush  in  1  discard window contents and restart fill (honoured in FILL only)
img  out  49  image window to multiplier, row r at [7r+:7]
w  out  49  weight kernel to multiplier, row r at [7r+:7]
mult_rst  out  1  clear pulse to multiplier accumulator/row counter
acc_en  out  1  accumulate strobe to multiplier (one row per cycle)
popcnt_in  in  7  multiplier accumulated popcount (registered in the multiplier)
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  7  captured popcount, unsigned 0..49
res_bit  out  1  (res_data >= THRESH)
busy  out  1  high in any state other than FILL

Behaviour:
- Reset, applied in any state including mid-sequence: state = FILL, row_cnt = 0, img = 0, w = 0. All of mult_rst, acc_en, res_valid, res_data, res_bit and busy are 0. Any in-flight sequence is abandoned.
- Weight load: on a w_load cycle in FILL, w <= {w[41:0], w_in}. Seven loads fill the kernel, with the first row ending up at [42+:7]. w_load in other states is ignored.
- Row accept: row_ready = (state==FILL) && !flush. On row_valid && row_ready: img <= {img[41:0], row_in} and row_cnt <= min(row_cnt+1, 7).
  - Because img and w use the same shift order, row alignment is preserved.
- Weight load and row accept in the same cycle both take effect.
- flush in FILL: row_cnt <= 0 and img <= 0. A row presented in the same cycle is not accepted. Weights are kept.
- FSM states: FILL, CLEAR, ACC, WAIT, OUT.
- FILL -> CLEAR on the edge where the accepted row makes row_cnt reach 7, or when row_cnt is already 7.
- CLEAR: mult_rst = 1 for exactly 1 cycle, then go to ACC.
- ACC: acc_en = 1 for exactly 7 consecutive cycles. A 3-bit step counter runs 0..6, then the FSM goes to WAIT.
- WAIT: 1 cycle, acc_en = 0. At the WAIT->OUT edge, capture res_data <= popcnt_in and res_bit <= (popcnt_in >= THRESH).
- OUT: res_valid = 1. res_data and res_bit are held stable until res_valid && res_ready. On that handshake: res_valid -> 0, state -> FILL, row_cnt <= 6 (vertical stride 1). The next accepted row therefore triggers a new window.
- img and w are held constant from CLEAR through WAIT, since no loads happen outside FILL.
- Latency: res_valid rises 9 cycles after the edge that accepts the 7th row (1 CLEAR + 7 ACC + 1 WAIT). Minimum period between results is 11 cycles (1 OUT + 1 row accept + 9).
- Backpressure: while res_ready is low, the feeder stays in OUT and row_ready = 0.
- busy = (state != FILL).
- mult_rst and acc_en are never high simultaneously.

Test Plan:
1. Load 7 weight rows of 7'h7F, stream 7 rows of 7'h7F, res_ready=1 -> acc_en high for 7 cycles after a single mult_rst pulse; res_valid 9 cycles after the 7th accept with res_data=49, res_bit=1.
2. Weights 7'h7F, rows 7'h00 -> res_data=0, res_bit=0. Weights 7'h55, rows 7'h55 -> res_data=49.
3. Threshold: weights 7'h7F. Rows 7'h07 (3 ones each) -> res_data=21, res_bit=0. Rows 7'h0F -> res_data=28, res_bit=1.
4. Sliding window: after test 1, accept one row 7'h00 -> second result 9 cycles later with res_data=42. Exactly one row is accepted between the two results.
5. Backpressure and flush:
   - Hold res_ready=0 for 5 cycles -> res_valid, res_data and res_bit stable, row_ready=0.
   - Then assert flush together with row_valid in FILL -> row not taken, row_cnt=0, and 7 new rows are needed before the next result.
6. Assert rst during the 4th ACC cycle -> next cycle: acc_en=0, res_valid=0, row_ready=1, img=0, w=0.
   - Reload weights and rows -> correct result (49 for an all-ones load).

Source files
------------

// File: rtl/bin_window_feeder_if.sv
// Handshake and data bus between the binary window feeder and its neighbours
// (row/weight source, XNOR-popcount multiplier, result sink).
interface bin_window_feeder_if;
    logic [6:0]  w_in;
    logic        w_load;
    logic [6:0]  row_in;
    logic        row_valid;
    logic        row_ready;
    logic        flush;
    logic [48:0] img;
    logic [48:0] w;
    logic        mult_rst;
    logic        acc_en;
    logic [6:0]  popcnt_in;
    logic        res_valid;
    logic        res_ready;
    logic [6:0]  res_data;
    logic        res_bit;
    logic        busy;

    modport master (
        output w_in, w_load, row_in, row_valid, flush, popcnt_in, res_ready,
        input  row_ready, img, w, mult_rst, acc_en, res_valid, res_data, res_bit, busy
    );

    modport slave (
        input  w_in, w_load, row_in, row_valid, flush, popcnt_in, res_ready,
        output row_ready, img, w, mult_rst, acc_en, res_valid, res_data, res_bit, busy
    );
endinterface

// File: rtl/bin_window_feeder.sv
// Sequencer that shift-loads a 7x7 binary kernel and sliding image window,
// strobes the XNOR-popcount multiplier for 7 rows and returns the thresholded sum.
module bin_window_feeder #(
    parameter int THRESH = 25
) (
    input  logic               clk,
    input  logic               rst,
    bin_window_feeder_if.slave bus_io
);
    typedef enum logic [2:0] {FILL, CLEAR, ACC, WAIT, OUT} state_e;

    localparam logic [6:0] THRESH_C = 7'(THRESH);

    state_e      state_q, state_d;
    logic [2:0]  row_cnt_q, row_cnt_d;
    logic [2:0]  step_q, step_d;
    logic [48:0] img_q, img_d;
    logic [48:0] w_q, w_d;
    logic [6:0]  res_data_q, res_data_d;
    logic        res_bit_q, res_bit_d;

    logic in_fill, row_acc, res_hs;

    assign in_fill = (state_q == FILL);
    assign row_acc = in_fill && !bus_io.flush && bus_io.row_valid;
    assign res_hs  = (state_q == OUT) && bus_io.res_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    // A flush always wins over starting a window in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (!bus_io.flush && (row_cnt_q == 3'd7 || (row_acc && row_cnt_q == 3'd6)))
                         state_d = CLEAR;
            CLEAR:   state_d = ACC;
            ACC:     if (step_q == 3'd6) state_d = WAIT;
            WAIT:    state_d = OUT;
            OUT:     if (bus_io.res_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        row_cnt_d  = row_cnt_q;
        img_d      = img_q;
        w_d        = w_q;
        res_data_d = res_data_q;
        res_bit_d  = res_bit_q;
        step_d     = (state_q == ACC) ? step_q + 3'd1 : 3'd0;

        if (in_fill && bus_io.w_load)
            w_d = {w_q[41:0], bus_io.w_in};

        if (in_fill && bus_io.flush) begin
            row_cnt_d = 3'd0;
            img_d     = '0;
        end else if (row_acc) begin
            img_d     = {img_q[41:0], bus_io.row_in};
            row_cnt_d = (row_cnt_q == 3'd7) ? 3'd7 : row_cnt_q + 3'd1;
        end

        // Multiplier output is registered, so the sum is settled during WAIT.
        if (state_q == WAIT) begin
            res_data_d = bus_io.popcnt_in;
            res_bit_d  = (bus_io.popcnt_in >= THRESH_C);
        end

        // Vertical stride 1: keep six rows so one more accept fires a window.
        if (res_hs)
            row_cnt_d = 3'd6;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt_q  <= 3'd0;
            step_q     <= 3'd0;
            img_q      <= '0;
            w_q        <= '0;
            res_data_q <= 7'd0;
            res_bit_q  <= 1'b0;
        end else begin
            row_cnt_q  <= row_cnt_d;
            step_q     <= step_d;
            img_q      <= img_d;
            w_q        <= w_d;
            res_data_q <= res_data_d;
            res_bit_q  <= res_bit_d;
        end
    end

    always_comb begin
        bus_io.row_ready = in_fill && !bus_io.flush;
        bus_io.mult_rst  = (state_q == CLEAR);
        bus_io.acc_en    = (state_q == ACC);
        bus_io.res_valid = (state_q == OUT);
        bus_io.busy      = !in_fill;
        bus_io.img       = img_q;
        bus_io.w         = w_q;
        bus_io.res_data  = res_data_q;
        bus_io.res_bit   = res_bit_q;
    end
endmodule
